// File: rtl/conv_dot_product_pe.sv
// rtl/conv_dot_product_pe.sv - pipelined signed dot-product processing element
//
// One cache line of image data and one of weights are accepted every cycle.
// Their signed dot product leaves after LATENCY = 2 + log2(N) cycles, where
// N = CACHE_WIDTH / WIDTH (a power of two, at least 2).
//
// Optional feature macro: CONV_PE_RELU_EN (clamp negative results to zero).
//
// Ports:
//   clk        - clock, all state on the rising edge
//   reset      - synchronous active-high reset, clears every pipeline register
//   id         - 8-bit tag travelling alongside the operands
//   in_data    - N signed WIDTH-bit image lanes, lane k at [k*WIDTH +: WIDTH]
//   weight_vec - N signed WIDTH-bit weight lanes, same packing
//   out_data   - saturated signed OUT_WIDTH-bit result, registered
//   out_id     - tag matching out_data, registered
module conv_dot_product_pe #(
    parameter int WIDTH       = 16,
    parameter int CACHE_WIDTH = 512,
    parameter int OUT_WIDTH   = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [7:0]             id,
    input  logic [CACHE_WIDTH-1:0] in_data,
    input  logic [CACHE_WIDTH-1:0] weight_vec,
    output logic [OUT_WIDTH-1:0]   out_data,
    output logic [7:0]             out_id
);

    localparam int N       = CACHE_WIDTH / WIDTH;
    localparam int LOG2N   = $clog2(N);
    localparam int PW      = 2 * WIDTH;
    localparam int SUMW    = PW + LOG2N;
    localparam int LATENCY = 2 + LOG2N;

    // All tree levels live in one flat bus. Level 0 holds the N products,
    // level l holds N>>l partial sums of PW+l bits each, so no level overflows.
    function automatic int lvl_off(input int l);
        int o;
        o = 0;
        for (int j = 0; j < l; j++) begin
            o += (N >> j) * (PW + j);
        end
        return o;
    endfunction

    localparam int TOT  = lvl_off(LOG2N + 1);
    localparam int FOFF = lvl_off(LOG2N);

    localparam logic signed [SUMW-1:0] SAT_MAX = {{(SUMW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [SUMW-1:0] SAT_MIN = {{(SUMW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    logic [TOT-1:0]         tree_d, tree_q;
    logic [OUT_WIDTH-1:0]   out_data_d, out_data_q;
    logic [LATENCY*8-1:0]   id_d, id_q;
    logic signed [SUMW-1:0] sum_fin;

    for (genvar l = 0; l <= LOG2N; l++) begin : g_lvl
        localparam int CNT = N >> l;
        localparam int LW  = PW + l;
        localparam int OFF = lvl_off(l);

        logic [CNT*LW-1:0] lvl_d;

        if (l == 0) begin : g_mul
            always_comb begin
                lvl_d = '0;
                for (int k = 0; k < CNT; k++) begin
                    lvl_d[k*LW +: LW] = PW'($signed(in_data[k*WIDTH +: WIDTH]))
                                      * PW'($signed(weight_vec[k*WIDTH +: WIDTH]));
                end
            end
        end else begin : g_add
            localparam int PLW  = LW - 1;
            localparam int POFF = lvl_off(l - 1);
            always_comb begin
                lvl_d = '0;
                for (int i = 0; i < CNT; i++) begin
                    lvl_d[i*LW +: LW] = LW'($signed(tree_q[POFF + (2*i)*PLW +: PLW]))
                                      + LW'($signed(tree_q[POFF + (2*i+1)*PLW +: PLW]));
                end
            end
        end

        assign tree_d[OFF +: CNT*LW] = lvl_d;
    end

    // Output stage: saturate the full-precision sum, then optionally rectify.
    always_comb begin
        sum_fin = $signed(tree_q[FOFF +: SUMW]);
        out_data_d = sum_fin[OUT_WIDTH-1:0];
        if (sum_fin > SAT_MAX) begin
            out_data_d = {1'b0, {(OUT_WIDTH-1){1'b1}}};
        end else if (sum_fin < SAT_MIN) begin
            out_data_d = {1'b1, {(OUT_WIDTH-1){1'b0}}};
        end
`ifdef CONV_PE_RELU_EN
        if (out_data_d[OUT_WIDTH-1]) begin
            out_data_d = '0;
        end
`endif
    end

    // Tag delay line: one slot per pipeline stage, newest tag in the low byte.
    always_comb begin
        id_d = {id_q[(LATENCY-1)*8-1:0], id};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tree_q     <= '0;
            out_data_q <= '0;
            id_q       <= '0;
        end else begin
            tree_q     <= tree_d;
            out_data_q <= out_data_d;
            id_q       <= id_d;
        end
    end

    assign out_data = out_data_q;
    assign out_id   = id_q[LATENCY*8-1 -: 8];

endmodule

// File: tb/tb_conv_dot_product_pe.sv
// tb/tb_conv_dot_product_pe.sv - self-checking bench for conv_dot_product_pe
module tb_conv_dot_product_pe;

    localparam int W  = 16;
    localparam int CW = 512;
    localparam int N  = CW / W;
    localparam int L  = 7;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

`ifdef CONV_PE_RELU_EN
    localparam logic [31:0] EXP_MIX = 32'd0;
    localparam logic [31:0] EXP_NEG = 32'd0;
`else
    localparam logic [31:0] EXP_MIX = 32'hFFFFFFE1;
    localparam logic [31:0] EXP_NEG = 32'h80000000;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [7:0]    id;
    logic [CW-1:0] in_data;
    logic [CW-1:0] weight_vec;
    logic [31:0]   out_data;
    logic [7:0]    out_id;

    always #5 clk = ~clk;

    conv_dot_product_pe #(.WIDTH(W), .CACHE_WIDTH(CW), .OUT_WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .id         (id),
        .in_data    (in_data),
        .weight_vec (weight_vec),
        .out_data   (out_data),
        .out_id     (out_id)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int edge_no = 0;
    int last_reset = -1;
    logic [31:0] rec_data [4096];
    logic [7:0]  rec_id   [4096];
    logic [31:0] exp_data;
    logic [7:0]  exp_id;

    // Reference: exact integer dot product, clamp to 32-bit signed, optional ReLU.
    function automatic logic [31:0] ref_dot(input logic [CW-1:0] a, input logic [CW-1:0] b);
        longint s;
        s = 0;
        for (int k = 0; k < N; k++) begin
            s += longint'($signed(a[k*W +: W])) * longint'($signed(b[k*W +: W]));
        end
        if (s > SMAX) s = SMAX;
        else if (s < SMIN) s = SMIN;
`ifdef CONV_PE_RELU_EN
        if (s < 0) s = 0;
`endif
        return s[31:0];
    endfunction

    function automatic logic [CW-1:0] rand_vec();
        logic [CW-1:0] v;
        for (int i = 0; i < CW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [CW-1:0] fill_vec(input logic [W-1:0] val);
        logic [CW-1:0] v;
        for (int k = 0; k < N; k++) v[k*W +: W] = val;
        return v;
    endfunction

    // Records what the inputs at this edge should produce, then advances one edge.
    task automatic step();
        edge_no++;
        rec_data[edge_no] = ref_dot(in_data, weight_vec);
        rec_id[edge_no]   = id;
        if (reset) last_reset = edge_no;
        @(posedge clk);
        #1;
    endtask

    // Output after edge e reflects the inputs of edge e-L+1, unless a reset
    // edge happened at or after that edge.
    task automatic model_expect();
        int src;
        src = edge_no - L + 1;
        if (src < 1 || last_reset >= src) begin
            exp_data = '0;
            exp_id   = '0;
        end else begin
            exp_data = rec_data[src];
            exp_id   = rec_id[src];
        end
    endtask

    task automatic drive_zero();
        id = 8'h00;
        in_data = '0;
        weight_vec = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            id = 8'($urandom);
            in_data = rand_vec();
            weight_vec = rand_vec();
            step();
            n_cmp++;
            if (out_data !== 32'd0 || out_id !== 8'd0) begin
                n_fail++;
                $display("FAIL reset_hold c%0d data=%h id=%h want 0/0", c, out_data, out_id);
            end
        end
        reset = 1'b0;
        drive_zero();
        for (int c = 0; c < L; c++) begin
            step();
            n_cmp++;
            if (out_data !== 32'd0 || out_id !== 8'd0) begin
                n_fail++;
                $display("FAIL reset_release c%0d data=%h id=%h want 0/0", c, out_data, out_id);
            end
        end
    endtask

    task automatic test_unit();
        id = 8'h05;
        in_data = fill_vec(16'd1);
        weight_vec = fill_vec(16'd2);
        step();
        drive_zero();
        for (int i = 1; i < L; i++) begin
            step();
            model_expect();
            n_cmp++;
            if (out_data !== exp_data || out_id !== exp_id) begin
                n_fail++;
                $display("FAIL unit_model i%0d data=%h id=%h want %h/%h", i, out_data, out_id, exp_data, exp_id);
            end
            if (i == L - 1) begin
                n_cmp++;
                if (out_data !== 32'd64 || out_id !== 8'h05) begin
                    n_fail++;
                    $display("FAIL unit_value data=%h id=%h want 00000040/05", out_data, out_id);
                end
            end
        end
    endtask

    task automatic test_signed_mix();
        drive_zero();
        id = 8'h11;
        in_data[0 +: W]    = -16'sd3;
        weight_vec[0 +: W] = 16'sd7;
        in_data[W +: W]    = 16'sd5;
        weight_vec[W +: W] = -16'sd2;
        step();
        drive_zero();
        for (int i = 1; i < L; i++) step();
        n_cmp++;
        if (out_data !== EXP_MIX || out_id !== 8'h11) begin
            n_fail++;
            $display("FAIL signed_mix data=%h id=%h want %h/11", out_data, out_id, EXP_MIX);
        end
    endtask

    task automatic test_saturation();
        id = 8'h21;
        in_data = fill_vec(16'h8000);
        weight_vec = fill_vec(16'h8000);
        step();
        id = 8'h22;
        in_data = fill_vec(16'h7FFF);
        step();
        drive_zero();
        for (int i = 1; i < L; i++) begin
            step();
            if (i == L - 2) begin
                n_cmp++;
                if (out_data !== 32'h7FFFFFFF || out_id !== 8'h21) begin
                    n_fail++;
                    $display("FAIL sat_pos data=%h id=%h want 7fffffff/21", out_data, out_id);
                end
            end
            if (i == L - 1) begin
                n_cmp++;
                if (out_data !== EXP_NEG || out_id !== 8'h22) begin
                    n_fail++;
                    $display("FAIL sat_neg data=%h id=%h want %h/22", out_data, out_id, EXP_NEG);
                end
            end
        end
    endtask

    task automatic test_streaming();
        for (int s = 0; s < 20 + L - 1; s++) begin
            if (s < 20) begin
                id = 8'(s);
                in_data = rand_vec();
                weight_vec = rand_vec();
            end else begin
                drive_zero();
            end
            step();
            model_expect();
            n_cmp++;
            if (out_data !== exp_data || out_id !== exp_id) begin
                n_fail++;
                $display("FAIL stream_model s%0d data=%h id=%h want %h/%h", s, out_data, out_id, exp_data, exp_id);
            end
            if (s >= L - 1) begin
                n_cmp++;
                if (out_id !== 8'(s - (L - 1))) begin
                    n_fail++;
                    $display("FAIL stream_order s%0d id=%h want %h", s, out_id, 8'(s - (L - 1)));
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [CW-1:0] a_keep, w_keep;
        for (int v = 0; v < 4; v++) begin
            id = 8'(8'h40 + v);
            in_data = rand_vec();
            weight_vec = rand_vec();
            step();
        end
        reset = 1'b1;
        id = 8'h44;
        in_data = rand_vec();
        weight_vec = rand_vec();
        step();
        n_cmp++;
        if (out_data !== 32'd0 || out_id !== 8'd0) begin
            n_fail++;
            $display("FAIL midrst_clear data=%h id=%h want 0/0", out_data, out_id);
        end
        reset = 1'b0;
        id = 8'hAA;
        a_keep = rand_vec();
        w_keep = rand_vec();
        in_data = a_keep;
        weight_vec = w_keep;
        step();
        drive_zero();
        for (int i = 1; i < L; i++) begin
            step();
            model_expect();
            n_cmp++;
            if (out_data !== exp_data || out_id !== exp_id || (out_id >= 8'h40 && out_id <= 8'h44)) begin
                n_fail++;
                $display("FAIL midrst_model i%0d data=%h id=%h want %h/%h", i, out_data, out_id, exp_data, exp_id);
            end
        end
        n_cmp++;
        if (out_id !== 8'hAA || out_data !== ref_dot(a_keep, w_keep)) begin
            n_fail++;
            $display("FAIL midrst_next data=%h id=%h want %h/aa", out_data, out_id, ref_dot(a_keep, w_keep));
        end
    endtask

    initial begin
        reset = 1'b1;
        id = 8'h00;
        in_data = '0;
        weight_vec = '0;
        test_reset();
        test_unit();
        test_signed_mix();
        test_saturation();
        test_streaming();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/conv_dot_product_pe.md
Name: conv_dot_product_pe

Overview:
- Single processing element of the convolution forward layer.
- Each cycle takes one cache line of image data and one cache line of filter weights, both packed vectors of signed WIDTH-bit lanes.
- Computes their signed dot product in a fully pipelined multiply/adder tree and emits one 32-bit result per cycle.
- Instantiated NUM_PE times inside the convolution array; every instance shares in_data and has its own weight_vec.

Parameters:
- WIDTH, 16: bit width of each signed lane element.
- CACHE_WIDTH, 512: width of the in_data and weight_vec buses; lane count N = CACHE_WIDTH/WIDTH (32 by default); N must be a power of two.
- OUT_WIDTH, 32: width of out_data.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- id  input  8  tag for the current input pair; travels with the data through the pipeline.
- in_data  input  CACHE_WIDTH  image vector; lane k = bits [(k+1)*WIDTH-1 : k*WIDTH], signed.
- weight_vec  input  CACHE_WIDTH  weight vector, same lane packing, signed.
- out_data  output  OUT_WIDTH  signed dot-product result, registered.
- out_id  output  8  id matching the current out_data, registered.

Behaviour:
- One clock, single-edge; no stalls. A new operand pair is accepted every cycle, unconditionally; there is no valid/ready handshake (the caller tracks validity by counting cycles).
- Stage 1 (multiply): register p[k] = in_data lane k × weight_vec lane k, signed, full 2*WIDTH bits, for all N lanes.
- Stages 2..1+log2(N) (adder tree): each level sums adjacent pairs and is registered. Each level grows by 1 bit, so there is no overflow inside the tree; the final sum is 2*WIDTH+log2(N) bits (37 by default).
- Final stage (output):
  - Saturate the sum to signed OUT_WIDTH: values > 2^(OUT_WIDTH-1)-1 clamp to 0x7FFFFFFF; values < -2^(OUT_WIDTH-1) clamp to 0x80000000.
  - Then apply the optional ReLU and register into out_data.
- Latency: LATENCY = 2 + log2(N) cycles (7 by default). Inputs sampled at edge t appear on out_data/out_id after edge t+LATENCY-1, i.e. stable during cycle t+LATENCY.
- id is delayed by exactly LATENCY stages, so out_id always labels out_data.
- Throughput: one result per cycle. Back-to-back inputs give back-to-back outputs in order.
- Reset:
  - When reset=1 at a clock edge, every pipeline register, out_data and out_id are cleared to 0.
  - Reset mid-operation discards all in-flight data. After reset deasserts, out_data stays 0 for LATENCY cycles when inputs are 0.
- Boundary behaviour:
  - All-zero inputs give 0.
  - Lane product (-32768)×(-32768) = 2^30 is representable.
  - 32 such lanes sum to 2^35, which saturates to 0x7FFFFFFF.

Optional Feature:
- Macro: CONV_PE_RELU_EN.
- When defined: after saturation, negative results are forced to 0 before registering out_data; non-negative results are unchanged.
- When undefined: out_data is the saturated signed sum, including negatives.
- Latency, out_id and reset behaviour are identical in both builds.

Test Plan:
- Reset: hold reset=1 for 3 cycles with random inputs -> out_data=0 and out_id=0 on every cycle; after deassert with zero inputs -> out_data stays 0.
- Unit dot product: all lanes in_data=1, weight_vec=2, id=0x05 -> exactly LATENCY cycles later out_data=64 (0x40), out_id=0x05.
- Signed mix: lane0 in=-3, w=7; lane1 in=5, w=-2; other lanes 0 -> out_data = -31 (0xFFFFFFE1) without CONV_PE_RELU_EN; 0 with it.
- Saturation: all lanes in=0x8000, w=0x8000 -> out_data=0x7FFFFFFF. All lanes in=0x7FFF, w=0x8000 -> out_data=0x80000000 without ReLU, 0 with it.
- Streaming: drive 20 consecutive random vectors with id=0..19 -> 20 consecutive outputs matching a reference model, out_id incrementing 0..19 with no gaps.
- Reset mid-stream: assert reset for 1 cycle while 4 vectors are in flight -> those results never appear (outputs 0); the next vector's result appears LATENCY cycles after it is applied.
